abr_prim_reg_adapter: RTL
=========================

// Module: abr_prim_reg_adapter
// PURPOSE
// - Upstream feeder for a bank of abr_prim_subreg slices.
// - Turns a valid/ready request/response bus into per-register one-cycle we/re strobes.
// - Provides a shared write-data word and collects register read data.
// - Subreg slices have no byte enables, so partial writes use read-modify-write against current qs.
// - One transaction in flight.
// PARAMETERS
// - NumRegs  8   number of attached registers; register i decodes at byte address 4*i.
// - AW       12  request byte-address width; must satisfy 2**AW >= 4*NumRegs.
// - DW       32  data width; fixed at 32 (elaboration assertion).
// PORTS
// - clk_i      in   1          clock
// - rst_b      in   1          asynchronous active-low reset
// - req_valid  in   1          request valid
// - req_ready  out  1          request ready
// - req_write  in   1          1 = write, 0 = read
// - req_addr   in   AW         byte address
// - req_wdata  in   DW         write data
// - req_wstrb  in   DW/8       byte strobes (writes only)
// - rsp_valid  out  1          response valid
// - rsp_ready  in   1          response ready
// - rsp_rdata  out  DW         read data; 0 for writes and errors
// - rsp_err    out  1          decode/alignment error
// - reg_we     out  NumRegs    one-hot write strobe to subreg we
// - reg_re     out  NumRegs    one-hot read strobe; drives we of RC-type subregs
// - reg_wd     out  DW         shared write data to all subreg wd
// - reg_qs     in   NumRegs*DW packed subreg qs; register i at [i*DW +: DW]
// BEHAVIOUR
// - Clock/reset: single clock clk_i; reset rst_b is asynchronous, active-low.
// - Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0,
//   reg_we=0, reg_re=0, reg_wd=0, all latched request fields 0.
// - FSM states: IDLE, EXEC, RESP.
//   - IDLE: req_ready=1. On req_valid, latch write/addr/wdata/wstrb -> EXEC.
//   - EXEC: req_ready=0. Exactly one cycle, then -> RESP.
//   - RESP: rsp_valid=1 and outputs held stable. On rsp_ready -> IDLE.
//     req_ready stays 0 in RESP; no overlap with the next request.
// - Latency and throughput: accept edge +2 cycles = rsp_valid; max one transaction per 3 cycles.
// - Decode, evaluated in EXEC on the latched address:
//   - error if addr[1:0] != 0;
//   - error if addr[AW-1:2] >= NumRegs.
//   - index = addr[AW-1:2].
// - Read, EXEC cycle:
//   - reg_re[index]=1 for that cycle only.
//   - rsp_rdata is registered from reg_qs[index], i.e. the value before any read-clear takes
//     effect at the same edge.
// - Write, EXEC cycle:
//   - reg_we[index]=1 iff wstrb != 0.
//   - reg_wd byte b = wstrb[b] ? wdata byte b : reg_qs[index] byte b.
//   - wstrb==0: no strobe, OK response.
// - Error in EXEC: no reg_we/reg_re; rsp_err=1; rsp_rdata=0.
// - Strobe hygiene:
//   - reg_we/reg_re are registered outputs, at most one bit high, only during EXEC.
//   - reg_wd is 0 outside write-EXEC.
// - Simultaneous events: rsp_ready with rsp_valid=0 is ignored; req_valid in EXEC/RESP is not
//   accepted (ready low), and the requester must hold it.
// - Reset mid-operation: return to IDLE immediately; pending strobe/response dropped; no
//   partial write issued after reset release.
// STRUCTURE
// - abr_prim_reg_adapter_pkg holds:
//   - state enum adapter_state_e {IDLE, EXEC, RESP};
//   - localparam BytesPerWord = DW/8;
//   - function strb_merge(old, new, strb).
// - Single module, no sub-module; the decoder and byte merge are a few lines each.
// TESTING
// - Reset then idle: req_ready=1, rsp_valid=0, reg_we=reg_re=0 throughout 10 cycles.
// - Full write: addr 0x8, wdata 0xDEADBEEF, wstrb 0xF.
//   -> EXEC reg_we=8'b0000_0100, reg_wd=0xDEADBEEF; rsp at +2, err=0.
// - Partial write: reg1 qs=0x11223344; addr 0x4, wdata 0xAABBCCDD, wstrb 0x5
//   -> reg_wd=0x11BB33DD, reg_we[1]=1.
// - Read of RC reg3 (qs=0x0000_00F0) -> reg_re[3] pulse 1 cycle, rsp_rdata=0xF0, err=0.
// - Errors, each with no strobes, err=1, rdata=0:
//   - addr 0x20 (NumRegs=8);
//   - addr 0x6 (misaligned).
// - Backpressure and reset:
//   - hold rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0;
//   - assert rst_b low in EXEC -> no reg_we after release, state IDLE.

Source files
------------

// File: rtl/abr_prim_reg_adapter_pkg.sv
// Shared types and helpers for the subreg bank request adapter.
package abr_prim_reg_adapter_pkg;

  localparam int AdapterDW    = 32;
  localparam int BytesPerWord = AdapterDW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } adapter_state_e;

  // Byte-wise merge: strobed bytes come from new_data, the rest keep old_data.
  function automatic logic [AdapterDW-1:0] strb_merge(
    input logic [AdapterDW-1:0]    old_data,
    input logic [AdapterDW-1:0]    new_data,
    input logic [BytesPerWord-1:0] strb
  );
    logic [AdapterDW-1:0] merged;
    merged = old_data;
    for (int b = 0; b < BytesPerWord; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = new_data[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/abr_prim_reg_adapter.sv
// Valid/ready request bus to one-cycle subreg we/re strobes, with read-modify-write
// for partial writes since the subreg slices have no byte enables.
module abr_prim_reg_adapter
  import abr_prim_reg_adapter_pkg::*;
#(
  parameter int NumRegs = 8,
  parameter int AW      = 12,
  parameter int DW      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_b,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [AW-1:0]         req_addr,
  input  logic [DW-1:0]         req_wdata,
  input  logic [DW/8-1:0]       req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic [NumRegs-1:0]    reg_we,
  output logic [NumRegs-1:0]    reg_re,
  output logic [DW-1:0]         reg_wd,
  input  logic [NumRegs*DW-1:0] reg_qs
);

  localparam int IdxW = AW - 2;

  if (DW != AdapterDW) begin : gen_dw_check
    $error("abr_prim_reg_adapter: DW must be 32");
  end

  if ((64'(1) << AW) < 64'(4 * NumRegs)) begin : gen_aw_check
    $error("abr_prim_reg_adapter: AW too small for NumRegs");
  end

  adapter_state_e      state_q, state_d;
  logic                accept;

  logic                lat_write;
  logic [AW-1:0]       lat_addr;
  logic [DW-1:0]       lat_wdata;
  logic [DW/8-1:0]     lat_wstrb;

  logic [IdxW-1:0]     req_idx, lat_idx;
  logic                req_err, lat_err;
  logic [NumRegs-1:0]  req_onehot;
  logic [DW-1:0]       lat_qs_word;

  // Address decode: word index plus misalignment / out-of-range error.
  always_comb begin
    req_idx    = req_addr[AW-1:2];
    lat_idx    = lat_addr[AW-1:2];
    req_err    = (req_addr[1:0] != 2'b00) || (int'(req_idx) >= NumRegs);
    lat_err    = (lat_addr[1:0] != 2'b00) || (int'(lat_idx) >= NumRegs);
    req_onehot = NumRegs'(1) << req_idx;
  end

  // Select the current qs of the latched register for read data and byte merge.
  always_comb begin
    lat_qs_word = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (lat_idx == IdxW'(i)) begin
        lat_qs_word = reg_qs[i*DW +: DW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; one transaction in flight, no overlap.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the request, launch strobes for the EXEC cycle, capture the response.
  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      reg_we    <= '0;
      reg_re    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      reg_we <= '0;
      reg_re <= '0;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wstrb <= req_wstrb;
        if (!req_err) begin
          if (req_write) begin
            if (|req_wstrb) begin
              reg_we <= req_onehot;
            end
          end else begin
            reg_re <= req_onehot;
          end
        end
      end
      if (state_q == EXEC) begin
        rsp_err   <= lat_err;
        rsp_rdata <= (!lat_err && !lat_write) ? lat_qs_word : '0;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Merged write word, driven only while a decoded write is executing.
  always_comb begin
    reg_wd = '0;
    if (state_q == EXEC && lat_write && !lat_err) begin
      reg_wd = strb_merge(lat_qs_word, lat_wdata, lat_wstrb);
    end
  end

endmodule
